// File: rtl/ddram_rom_arbiter.sv
// ddram_rom_arbiter: owns the DDRAM Avalon port and shares it between the
// ROM loader write path and the core ROM fetch path, with a one-word cache.

module ddram_rom_arbiter #(
    parameter logic [28:0] BASE_ADDR = 29'h0600000,
    parameter bit          CACHE_EN  = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [24:0] wraddr,
    input  logic [15:0] din,
    input  logic        we_req,
    output logic        we_ack,
    input  logic [24:0] rdaddr,
    output logic [63:0] dout,
    input  logic        rd_req,
    output logic        rd_ack,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    output logic        DDRAM_RD,
    output logic        DDRAM_WE,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY
);

    typedef enum logic [1:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        wr_pend;
    logic        rd_pend;
    logic        hit;
    logic        rd_accept;
    logic        rd_done;
    logic        drain;
    logic        cache_valid;
    logic [21:0] cache_tag;
    logic [63:0] cache_data;
    logic [21:0] lat_word;
    logic        unused_bits;

    assign wr_pend     = we_req ^ we_ack;
    assign rd_pend     = rd_req ^ rd_ack;
    assign hit         = CACHE_EN && cache_valid
                         && (cache_tag == rdaddr[24:3]);
    assign rd_accept   = (state == RD_ISSUE) && !DDRAM_BUSY;
    assign rd_done     = DDRAM_DOUT_READY
                         && (rd_accept || state == RD_WAIT);
    assign unused_bits = ^{wraddr[0], rdaddr[2:0]};

    // State register.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: writes win, cache hits stay in IDLE, drain blocks all.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (drain) begin
                    state_nxt = IDLE;
                end else if (wr_pend) begin
                    state_nxt = WR_ISSUE;
                end else if (rd_pend && !hit) begin
                    state_nxt = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (!DDRAM_BUSY) begin
                    state_nxt = IDLE;
                end
            end
            RD_ISSUE: begin
                if (!DDRAM_BUSY) begin
                    state_nxt = DDRAM_DOUT_READY ? IDLE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (DDRAM_DOUT_READY) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Command strobes decode straight from the registered state.
    always_comb begin
        DDRAM_WE       = (state == WR_ISSUE);
        DDRAM_RD       = (state == RD_ISSUE);
        DDRAM_BURSTCNT = 8'd1;
    end

    // Drain survives reset so a read left in flight gets swallowed.
    always_ff @(posedge clk_sys) begin
        if (DDRAM_DOUT_READY) begin
            drain <= 1'b0;
        end else if (rd_accept) begin
            drain <= 1'b1;
        end
    end

    // Request latching, acks, read data and cache maintenance.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            we_ack      <= 1'b0;
            rd_ack      <= 1'b0;
            dout        <= '0;
            DDRAM_ADDR  <= '0;
            DDRAM_DIN   <= '0;
            DDRAM_BE    <= '0;
            cache_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!drain && wr_pend) begin
                        lat_word   <= wraddr[24:3];
                        DDRAM_ADDR <= BASE_ADDR + {7'd0, wraddr[24:3]};
                        DDRAM_DIN  <= {4{din}};
                        DDRAM_BE   <= 8'b11 << {wraddr[2:1], 1'b0};
                    end else if (!drain && rd_pend) begin
                        if (hit) begin
                            dout   <= cache_data;
                            rd_ack <= ~rd_ack;
                        end else begin
                            lat_word   <= rdaddr[24:3];
                            DDRAM_ADDR <= BASE_ADDR + {7'd0, rdaddr[24:3]};
                        end
                    end
                end
                WR_ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        we_ack <= ~we_ack;
                        if (cache_tag == lat_word) begin
                            cache_valid <= 1'b0;
                        end
                    end
                end
                RD_ISSUE, RD_WAIT: begin
                    if (rd_done) begin
                        dout        <= DDRAM_DOUT;
                        cache_data  <= DDRAM_DOUT;
                        cache_tag   <= lat_word;
                        cache_valid <= 1'b1;
                        rd_ack      <= ~rd_ack;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_rom_arbiter.sv
// tb_ddram_rom_arbiter: random requester traffic against a DDRAM slave model
// and a word-level memory/cache reference; directed corner cases first.

module tb_ddram_rom_arbiter;

    localparam logic [28:0] BASE  = 29'h0600000;
    localparam logic [28:0] WBASE = 29'h1FFFFFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [24:0] wraddr;
    logic [15:0] din;
    logic        we_req;
    logic        we_ack;
    logic [24:0] rdaddr;
    logic [63:0] dout;
    logic        rd_req;
    logic        rd_ack;
    logic        busy;
    logic [7:0]  burstcnt;
    logic [28:0] addr;
    logic        rd;
    logic        we;
    logic [63:0] ddin;
    logic [7:0]  be;
    logic [63:0] ddout;
    logic        dready;

    logic [24:0] w_wraddr;
    logic [15:0] w_din;
    logic        w_we_req;
    logic        w_we_ack;
    logic [24:0] w_rdaddr;
    logic [63:0] w_dout;
    logic        w_rd_req;
    logic        w_rd_ack;
    logic        w_busy;
    logic [7:0]  w_burstcnt;
    logic [28:0] w_addr;
    logic        w_rd;
    logic        w_we;
    logic [63:0] w_ddin;
    logic [7:0]  w_be;
    logic [63:0] w_ddout;
    logic        w_dready;

    always #5 clk = ~clk;

    ddram_rom_arbiter #(.BASE_ADDR(BASE), .CACHE_EN(1'b1)) u_dut (
        .clk_sys(clk), .reset_n(reset_n),
        .wraddr(wraddr), .din(din), .we_req(we_req), .we_ack(we_ack),
        .rdaddr(rdaddr), .dout(dout), .rd_req(rd_req), .rd_ack(rd_ack),
        .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(burstcnt),
        .DDRAM_ADDR(addr), .DDRAM_RD(rd), .DDRAM_WE(we),
        .DDRAM_DIN(ddin), .DDRAM_BE(be),
        .DDRAM_DOUT(ddout), .DDRAM_DOUT_READY(dready)
    );

    ddram_rom_arbiter #(.BASE_ADDR(WBASE), .CACHE_EN(1'b0)) u_wrap (
        .clk_sys(clk), .reset_n(reset_n),
        .wraddr(w_wraddr), .din(w_din), .we_req(w_we_req),
        .we_ack(w_we_ack),
        .rdaddr(w_rdaddr), .dout(w_dout), .rd_req(w_rd_req),
        .rd_ack(w_rd_ack),
        .DDRAM_BUSY(w_busy), .DDRAM_BURSTCNT(w_burstcnt),
        .DDRAM_ADDR(w_addr), .DDRAM_RD(w_rd), .DDRAM_WE(w_we),
        .DDRAM_DIN(w_ddin), .DDRAM_BE(w_be),
        .DDRAM_DOUT(w_ddout), .DDRAM_DOUT_READY(w_dready)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          auto_en = 1'b0;
    bit          hold_ret = 1'b0;
    int          busy_pct = 30;
    int          busy_hold = 0;
    int          rd_cnt = 0;
    logic [63:0] rd_data;
    int          n_ddr_rd = 0;
    int          acc_cyc = 0;

    logic [63:0] mem [logic [28:0]];
    logic [63:0] ref_mem [logic [21:0]];
    bit          cv = 1'b0;
    logic [21:0] cw;

    logic [28:0] exp_w_addr;
    logic [63:0] exp_w_din;
    logic [7:0]  exp_w_be;
    logic [28:0] exp_r_addr;
    bit          wr_out = 1'b0;
    bit          rd_out = 1'b0;
    bit          rd_alone;
    bit          exp_hit;
    logic [63:0] exp_dout;
    logic [21:0] rd_w;
    int          rd_before;
    int          rd_t0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input logic [28:0] a);
        return {3'b000, a, 3'b101, ~a};
    endfunction

    function automatic logic [63:0] mem_rd(input logic [28:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [28:0] word_addr(input logic [21:0] w);
        return BASE + {7'd0, w};
    endfunction

    function automatic logic [63:0] ref_rd(input logic [21:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(word_addr(w));
    endfunction

    task automatic preload(input logic [21:0] w, input logic [63:0] v);
        mem[word_addr(w)] = v;
        ref_mem[w] = v;
    endtask

    // DDRAM slave model: random waitrequest, random read latency.
    task automatic slave();
        logic [63:0] m;
        int          lat;
        dready = 1'b0;
        ddout  = {$urandom, $urandom};
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                dready = 1'b1;
                ddout  = rd_data;
            end
        end
        if (we) begin
            chk("wr_addr", 64'(addr), 64'(exp_w_addr));
            chk("wr_din", ddin, exp_w_din);
            chk("wr_be", 64'(be), 64'(exp_w_be));
        end
        if (rd) begin
            chk("rd_addr", 64'(addr), 64'(exp_r_addr));
        end
        if (we || rd) begin
            if (busy_hold > 0) begin
                busy = 1'b1;
                busy_hold--;
            end else begin
                busy = ($urandom_range(0, 99) < busy_pct);
            end
        end else begin
            busy = 1'($urandom_range(0, 1));
        end
        if (we && !busy) begin
            m = mem_rd(addr);
            for (int b = 0; b < 8; b++) begin
                if (be[b]) m[8*b +: 8] = ddin[8*b +: 8];
            end
            mem[addr] = m;
            acc_cyc = cyc;
        end
        if (rd && !busy) begin
            n_ddr_rd++;
            if (!hold_ret) begin
                rd_data = mem_rd(addr);
                lat = $urandom_range(0, 3);
                if (lat == 0) begin
                    dready = 1'b1;
                    ddout  = rd_data;
                end else begin
                    rd_cnt = lat;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("we_rd_excl", 64'(we & rd), 64'd0);
        if (rd) chk("rd_after_wr", 64'(we_req ^ we_ack), 64'd0);
        if (auto_en) slave();
    endtask

    task automatic wr_start(input logic [24:0] a, input logic [15:0] d);
        logic [63:0] v;
        int          h;
        logic [21:0] w;
        w = a[24:3];
        h = int'(a[2:1]);
        wraddr = a;
        din = d;
        exp_w_addr = word_addr(w);
        exp_w_din = {d, d, d, d};
        exp_w_be = '0;
        exp_w_be[2*h] = 1'b1;
        exp_w_be[2*h+1] = 1'b1;
        v = ref_rd(w);
        v[16*h +: 16] = d;
        ref_mem[w] = v;
        if (cv && cw == w) cv = 1'b0;
        wr_out = 1'b1;
        we_req = ~we_req;
    endtask

    task automatic rd_start(input logic [24:0] a);
        rd_w = a[24:3];
        rdaddr = a;
        exp_hit = cv && (cw == rd_w);
        exp_r_addr = word_addr(rd_w);
        exp_dout = ref_rd(rd_w);
        rd_before = n_ddr_rd;
        rd_t0 = cyc;
        rd_alone = !wr_out;
        rd_out = 1'b1;
        rd_req = ~rd_req;
    endtask

    task automatic wait_ops(input bit scr);
        int n = 0;
        int wack = -1;
        int rack = -1;
        while (((wr_out && we_ack !== we_req) ||
                (rd_out && rd_ack !== rd_req)) && n < 400) begin
            step();
            n++;
            if (scr && n == 1) begin
                wraddr = 25'($urandom);
                din    = 16'($urandom);
                rdaddr = 25'($urandom);
            end
            if (wr_out && wack < 0 && we_ack === we_req) wack = cyc;
            if (rd_out && rack < 0 && rd_ack === rd_req) rack = cyc;
        end
        if (wr_out) begin
            chk("we_ack", 64'(we_ack), 64'(we_req));
            chk("we_ack_lat", 64'(wack - acc_cyc), 64'd1);
            wr_out = 1'b0;
        end
        if (rd_out) begin
            chk("rd_ack", 64'(rd_ack), 64'(rd_req));
            chk("dout", dout, exp_dout);
            chk("ddr_reads", 64'(n_ddr_rd - rd_before),
                exp_hit ? 64'd0 : 64'd1);
            if (rd_alone && exp_hit) begin
                chk("hit_lat", 64'(rack - rd_t0), 64'd1);
            end
            if (!exp_hit) begin
                cv = 1'b1;
                cw = rd_w;
            end
            rd_out = 1'b0;
        end
    endtask

    task automatic wrap_read(input logic [63:0] v);
        logic [28:0] e;
        int          n = 0;
        e = WBASE + 29'd1;
        w_rdaddr = 25'h000008;
        w_rd_req = ~w_rd_req;
        while (!w_rd && n < 20) begin
            step();
            n++;
        end
        chk("wrap_rd", 64'(w_rd), 64'd1);
        chk("wrap_addr", 64'(w_addr), 64'(e));
        chk("wrap_we", 64'(w_we), 64'd0);
        w_ddout = v;
        w_dready = 1'b1;
        step();
        w_dready = 1'b0;
        chk("wrap_ack", 64'(w_rd_ack), 64'(w_rd_req));
        chk("wrap_dout", w_dout, v);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        wraddr = '0; din = '0; we_req = 1'b0;
        rdaddr = '0; rd_req = 1'b0;
        busy = 1'b0; ddout = '0; dready = 1'b1;
        w_wraddr = '0; w_din = '0; w_we_req = 1'b0;
        w_rdaddr = '0; w_rd_req = 1'b0;
        w_busy = 1'b0; w_ddout = '0; w_dready = 1'b1;
        step();
        dready = 1'b0;
        w_dready = 1'b0;
        step();
        step();
        chk("rst_we_ack", 64'(we_ack), 64'd0);
        chk("rst_rd_ack", 64'(rd_ack), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_din", ddin, 64'd0);
        chk("rst_be", 64'(be), 64'd0);
        chk("rst_burst", 64'(burstcnt), 64'd1);
        chk("rst_w_burst", 64'(w_burstcnt), 64'd1);
        chk("rst_w_din", w_ddin, 64'd0);
        chk("rst_w_be", 64'(w_be), 64'd0);
        chk("rst_w_ack", 64'(w_we_ack), 64'd0);
        reset_n = 1'b1;
        auto_en = 1'b1;
        step();

        wr_start(25'h000006, 16'hBEEF);
        wait_ops(1'b1);
        chk("be_c0", 64'(exp_w_be), 64'hC0);
        preload(22'd0, 64'h0123456789ABCDEF);
        rd_start(25'h000000);
        wait_ops(1'b1);
        chk("first_read", dout, 64'h0123456789ABCDEF);
        rd_start(25'h000000);
        wait_ops(1'b1);
        chk("hit_read", dout, 64'h0123456789ABCDEF);
        wr_start(25'h000002, 16'h5A5A);
        wait_ops(1'b1);
        rd_start(25'h000000);
        wait_ops(1'b1);
        chk("inval_read", dout, 64'h012345675A5ACDEF);

        busy_hold = 5;
        wr_start(25'h000010, 16'h1357);
        rd_start(25'h000018);
        wait_ops(1'b0);

        hold_ret = 1'b1;
        rd_start(25'd160);
        n = 0;
        while (n_ddr_rd == rd_before && n < 50) begin
            step();
            n++;
        end
        step();
        rd_out = 1'b0;
        auto_en = 1'b0;
        busy = 1'b0;
        dready = 1'b0;
        reset_n = 1'b0;
        we_req = 1'b0;
        rd_req = 1'b0;
        step();
        reset_n = 1'b1;
        cv = 1'b0;
        chk("mid_rst_ack", 64'(rd_ack), 64'd0);
        chk("mid_rst_dout", dout, 64'd0);
        preload(22'd21, 64'h1234);
        rd_start(25'd168);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drain_idle", 64'(rd), 64'd0);
        end
        ddout = 64'hDEAD;
        dready = 1'b1;
        step();
        dready = 1'b0;
        chk("beat_ack", 64'(rd_ack), 64'd0);
        chk("beat_dout", dout, 64'd0);
        hold_ret = 1'b0;
        auto_en = 1'b1;
        wait_ops(1'b0);
        chk("after_drain", dout, 64'h1234);

        for (int i = 0; i < 400; i++) begin
            int          r;
            logic [24:0] a;
            logic [24:0] b;
            busy_pct = $urandom_range(0, 60);
            r = $urandom_range(0, 9);
            a = 25'($urandom_range(0, 5) * 8 + $urandom_range(0, 7));
            b = 25'($urandom_range(0, 5) * 8 + $urandom_range(0, 7));
            if (r < 3) begin
                wr_start(a, 16'($urandom));
                wait_ops(1'b1);
            end else if (r < 8) begin
                rd_start(b);
                wait_ops(1'b1);
            end else begin
                wr_start(a, 16'($urandom));
                rd_start(b);
                wait_ops(1'b0);
            end
        end

        auto_en = 1'b0;
        wrap_read(64'h0F0E0D0C0B0A0908);
        wrap_read(64'h1122334455667788);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ddram_rom_arbiter.md
Name: ddram_rom_arbiter

Overview:
- Owns the single DDRAM Avalon port for the Genesis core.
- Shares it between two toggle-handshake requesters:
  - the ROM loader's 16-bit write path, fed from ioctl;
  - the core's 64-bit ROM fetch path, fed from Virtual_Toplevel ROM_REQ/ROM_ACK.
- Write priority over read; one-word read cache so repeated fetches of the same 64-bit word skip DDRAM.
- Sits between the emu top level and DDRAM_*; replaces direct requester-to-DDRAM wiring.

Parameters:
- BASE_ADDR, 29'h0600000: DDRAM 64-bit word address where ROM byte 0 lives.
- CACHE_EN, 1: 1 enables the one-word read cache; 0 sends every read to DDRAM.

Ports:
- clk_sys in 1: system clock; all logic on rising edge.
- reset_n in 1: synchronous, active-low reset.
- wraddr in 25: write byte address; bit 0 ignored.
- din in 16: write data.
- we_req in 1: write request toggle.
- we_ack out 1: write ack toggle.
- rdaddr in 25: read byte address; bits [2:0] ignored.
- dout out 64: read data.
- rd_req in 1: read request toggle.
- rd_ack out 1: read ack toggle.
- DDRAM_BUSY in 1: Avalon waitrequest.
- DDRAM_BURSTCNT out 8: burst count, constant 1.
- DDRAM_ADDR out 29: word address.
- DDRAM_RD out 1: read command.
- DDRAM_WE out 1: write command.
- DDRAM_DIN out 64: write data.
- DDRAM_BE out 8: byte enables.
- DDRAM_DOUT in 64: read return data.
- DDRAM_DOUT_READY in 1: read data valid.

Behaviour:
- Reset (reset_n=0 at a clock edge): we_ack=0, rd_ack=0, dout=0, DDRAM_RD=0, DDRAM_WE=0, DDRAM_ADDR=0, DDRAM_DIN=0, DDRAM_BE=0, DDRAM_BURSTCNT=1, cache invalid, state IDLE.
- Pending condition: a request is pending when its req differs from its ack. Ack toggles exactly once per serviced request.
- Address mapping: DDRAM_ADDR = BASE_ADDR + addr[24:3], modulo 2^29.
- Write data: DDRAM_DIN = {din,din,din,din}.
- Write enables: DDRAM_BE = 8'b11 << (2*wraddr[2:1]).
- States:
  - IDLE, write pending: latch address, data and BE; assert DDRAM_WE; go WR_ISSUE. A write wins when both are pending.
  - IDLE, read pending with cache hit: cache valid, CACHE_EN=1, tag == rdaddr[24:3]. On the next edge, dout = cache data and rd_ack toggles. Hit latency is 1 cycle from the pending edge.
  - IDLE, read pending otherwise: assert DDRAM_RD; go RD_ISSUE.
  - WR_ISSUE: hold WE, ADDR, DIN and BE stable while DDRAM_BUSY=1. On the first edge with BUSY=0, deassert WE, toggle we_ack and go IDLE. If the cache tag equals the written word, invalidate the cache.
  - RD_ISSUE: hold RD and ADDR while BUSY=1. On an edge with BUSY=0, deassert RD and go RD_WAIT. If DOUT_READY is already 1 on that edge, take the data and complete as in RD_WAIT.
  - RD_WAIT: on DOUT_READY=1, dout = DDRAM_DOUT, cache data = DDRAM_DOUT, tag = latched word address, cache valid, toggle rd_ack, go IDLE. There is no timeout.
- Read-after-write: a read pending during a write is evaluated only after the write acks, so it never returns stale cache data.
- Stable inputs: requester inputs are sampled only when leaving IDLE. Changes to rdaddr or wraddr while a request is in service are ignored until the next request.
- Reset mid-read:
  - A one-bit drain counter is exempt from reset. It is set when RD is accepted and cleared on DOUT_READY.
  - After reset, if drain is set, the FSM stays in IDLE and ignores requests until a DOUT_READY beat arrives. That beat is discarded and does not update dout or the cache.
- Reset mid-write: an accepted write completes in DDRAM and is not retried. we_ack resets to 0, so the requester must also reset its we_req to 0.
- At most one DDRAM command is outstanding at any time, and WE and RD are never both high.

Test Plan:
- Write then read:
  - BASE_ADDR=29'h0600000.
  - Write wraddr=0x000006, din=0xBEEF: DDRAM_ADDR=0x0600000, BE=8'hC0, DIN=0xBEEF repeated four times. we_ack toggles one cycle after WE is accepted.
  - Read rdaddr=0x000000: DDRAM_RD issued; DOUT=64'h0123456789ABCDEF returns on dout, rd_ack toggles.
- Cache hit: repeat the read of 0x000000. No DDRAM_RD is asserted; rd_ack toggles one cycle after the request; dout=64'h0123456789ABCDEF. With CACHE_EN=0, DDRAM_RD is asserted.
- Invalidation: write 0x000002 then read 0x000000. DDRAM_RD must be reissued.
- Simultaneous requests:
  - Toggle we_req and rd_req on the same edge; the write is issued first.
  - Hold BUSY=1 for 5 cycles; WE, ADDR, DIN and BE stay constant.
  - The read is issued only after we_ack toggles.
- Reset mid-read:
  - Assert reset_n=0 for one cycle while in RD_WAIT, then toggle rd_req.
  - Return one DOUT_READY beat with 64'hDEAD: it is discarded and rd_ack does not toggle.
  - A second beat 64'h1234 completes the new read.
- Address wrap: BASE_ADDR=29'h1FFFFFFF, rdaddr=0x000008 -> DDRAM_ADDR=0x0000000.
